// File: rtl/perf_window_sampler.sv
// ---------------------------------------------------------------------------
// perf_window_sampler
//
// Windowed performance sampler that sits downstream of the writeback-stage
// cycle/retire monitor. The monitor supplies free-running cumulative 32-bit
// counters. Every WINDOW enabled cycles this block takes the difference
// between the live counters and a snapshot taken at the previous window
// boundary. It pushes the resulting record {window index, six deltas} into a
// small show-ahead FIFO. A consumer drains the FIFO over a valid/ready
// handshake.
//
// Parameters
//   WINDOW : enabled cycles per sample window (>= 2)
//   DEPTH  : sample FIFO entries (power of two, >= 2)
//
// Ports
//   clk_i            : clock
//   reset_i          : synchronous active-high reset; clears all state
//   enable_i         : window counter advances only while high
//   clear_i          : restart the window and re-baseline the snapshots
//                      (FIFO, window index and drop statistics untouched)
//   cycle_cnt_i      : cumulative cycle counter from the monitor
//   retire_cnt_i     : cumulative retired-instruction counter
//   alu_op_cnt_i     : cumulative ALU op counter
//   load_op_cnt_i    : cumulative load op counter
//   store_op_cnt_i   : cumulative store op counter
//   branch_op_cnt_i  : cumulative branch op counter
//   sample_ready_i   : consumer accepts the head record this cycle
//   sample_valid_o   : FIFO is non-empty
//   sample_index_o   : window number of the head record
//   sample_*_o       : per-window deltas of the head record
//   overflow_o       : sticky flag, at least one record was dropped
//   drop_cnt_o       : number of dropped records, saturating at 0xFFFF
// ---------------------------------------------------------------------------
module perf_window_sampler #(
  parameter int unsigned WINDOW = 1000,
  parameter int unsigned DEPTH  = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        clear_i,
  input  logic [31:0] cycle_cnt_i,
  input  logic [31:0] retire_cnt_i,
  input  logic [31:0] alu_op_cnt_i,
  input  logic [31:0] load_op_cnt_i,
  input  logic [31:0] store_op_cnt_i,
  input  logic [31:0] branch_op_cnt_i,
  input  logic        sample_ready_i,
  output logic        sample_valid_o,
  output logic [31:0] sample_index_o,
  output logic [31:0] sample_cycles_o,
  output logic [31:0] sample_retire_o,
  output logic [31:0] sample_alu_o,
  output logic [31:0] sample_load_o,
  output logic [31:0] sample_store_o,
  output logic [31:0] sample_branch_o,
  output logic        overflow_o,
  output logic [15:0] drop_cnt_o
);

  localparam int unsigned CNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam int unsigned PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

  // One FIFO entry: the window number followed by the six deltas.
  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] cycles;
    logic [31:0] retire;
    logic [31:0] alu;
    logic [31:0] load;
    logic [31:0] store;
    logic [31:0] branch;
  } sample_rec_t;

  logic [CNT_W-1:0] win_cnt;
  logic [31:0]      win_idx;

  logic [31:0] snap_cycles;
  logic [31:0] snap_retire;
  logic [31:0] snap_alu;
  logic [31:0] snap_load;
  logic [31:0] snap_store;
  logic [31:0] snap_branch;

  sample_rec_t      fifo_mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W-1:0] wr_addr;
  logic [PTR_W-1:0] rd_addr;

  logic        capture;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;
  logic        push;
  logic        drop;
  sample_rec_t new_rec;
  sample_rec_t head_rec;

  // A capture fires on the last enabled cycle of a window. A clear in the
  // same cycle suppresses it, so the window simply restarts.
  assign capture = enable_i && !clear_i && (win_cnt == WIN_LAST);

  // Window position counter. Clear restarts it regardless of enable_i.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      win_cnt <= '0;
    end else if (clear_i) begin
      win_cnt <= '0;
    end else if (enable_i) begin
      if (win_cnt == WIN_LAST) begin
        win_cnt <= '0;
      end else begin
        win_cnt <= win_cnt + CNT_W'(1);
      end
    end
  end

  // Snapshots re-baseline on every capture and on every clear. Between
  // those events they hold. Anything counted while enable_i is low
  // therefore lands in the next captured delta.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      snap_cycles <= '0;
      snap_retire <= '0;
      snap_alu    <= '0;
      snap_load   <= '0;
      snap_store  <= '0;
      snap_branch <= '0;
    end else if (clear_i || capture) begin
      snap_cycles <= cycle_cnt_i;
      snap_retire <= retire_cnt_i;
      snap_alu    <= alu_op_cnt_i;
      snap_load   <= load_op_cnt_i;
      snap_store  <= store_op_cnt_i;
      snap_branch <= branch_op_cnt_i;
    end
  end

  // The window index advances on every capture, even when the record is
  // dropped. This lets the consumer detect lost windows as index gaps.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      win_idx <= '0;
    end else if (capture) begin
      win_idx <= win_idx + 32'd1;
    end
  end

  // Deltas use plain modulo-2^32 subtraction, so a counter that wrapped
  // inside the window still yields the correct count.
  always_comb begin
    new_rec        = '0;
    new_rec.idx    = win_idx;
    new_rec.cycles = cycle_cnt_i     - snap_cycles;
    new_rec.retire = retire_cnt_i    - snap_retire;
    new_rec.alu    = alu_op_cnt_i    - snap_alu;
    new_rec.load   = load_op_cnt_i   - snap_load;
    new_rec.store  = store_op_cnt_i  - snap_store;
    new_rec.branch = branch_op_cnt_i - snap_branch;
  end

  // The pointers carry one extra wrap bit. Equal pointers mean empty.
  // Equal addresses with different wrap bits mean full.
  assign wr_addr    = wr_ptr[PTR_W-1:0];
  assign rd_addr    = rd_ptr[PTR_W-1:0];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_addr == rd_addr);

  // A full FIFO still takes the new record when the head leaves in the
  // same cycle. The write then lands in the slot being vacated.
  assign pop  = !fifo_empty && sample_ready_i;
  assign push = capture && (!fifo_full || pop);
  assign drop = capture && fifo_full && !pop;

  // Record storage. It is cleared on reset so that every output reads
  // zero coming out of reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_mem[PTR_W'(i)] <= '0;
      end
    end else if (push) begin
      fifo_mem[wr_addr] <= new_rec;
    end
  end

  // Read and write pointers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
    end
  end

  // Drop bookkeeping. The overflow flag is sticky until reset. The drop
  // counter stops at all-ones rather than wrapping back to zero.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_cnt_o != 16'hFFFF) begin
        drop_cnt_o <= drop_cnt_o + 16'd1;
      end
    end
  end

  // Show-ahead read port. The outputs come straight from storage at the
  // registered read pointer. sample_ready_i affects them only through the
  // pointer update at the clock edge.
  assign head_rec        = fifo_mem[rd_addr];
  assign sample_valid_o  = !fifo_empty;
  assign sample_index_o  = head_rec.idx;
  assign sample_cycles_o = head_rec.cycles;
  assign sample_retire_o = head_rec.retire;
  assign sample_alu_o    = head_rec.alu;
  assign sample_load_o   = head_rec.load;
  assign sample_store_o  = head_rec.store;
  assign sample_branch_o = head_rec.branch;

endmodule

// File: tb/tb_perf_window_sampler.sv
// ---------------------------------------------------------------------------
// tb_perf_window_sampler
//
// Self-checking bench for perf_window_sampler built with WINDOW=4, DEPTH=2.
// A behavioural model advances on every rising edge and pushes each record
// it expects the FIFO to accept into a queue. On the falling edge before
// every rising edge, the DUT head is compared with the front of that queue
// whenever a pop is about to happen. Valid, overflow and drop count are
// compared every cycle. Each scenario task also checks hand-derived values
// at the cycles that matter.
// ---------------------------------------------------------------------------
module tb_perf_window_sampler;

  localparam int W = 4;
  localparam int D = 2;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        enable_i = 1'b1;
  logic        clear_i = 1'b0;
  logic [31:0] cycle_cnt_i = '0;
  logic [31:0] retire_cnt_i = '0;
  logic [31:0] alu_op_cnt_i = '0;
  logic [31:0] load_op_cnt_i = '0;
  logic [31:0] store_op_cnt_i = '0;
  logic [31:0] branch_op_cnt_i = '0;
  logic        sample_ready_i = 1'b1;
  logic        sample_valid_o;
  logic [31:0] sample_index_o;
  logic [31:0] sample_cycles_o;
  logic [31:0] sample_retire_o;
  logic [31:0] sample_alu_o;
  logic [31:0] sample_load_o;
  logic [31:0] sample_store_o;
  logic [31:0] sample_branch_o;
  logic        overflow_o;
  logic [15:0] drop_cnt_o;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] cyc;
    logic [31:0] ret;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] st;
    logic [31:0] br;
  } rec_t;

  rec_t        exp_q[$];
  int          m_wc = 0;
  logic [31:0] m_idx = '0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_drop = '0;
  logic [31:0] m_s_cyc = '0, m_s_ret = '0, m_s_alu = '0;
  logic [31:0] m_s_ld = '0, m_s_st = '0, m_s_br = '0;

  perf_window_sampler #(.WINDOW(W), .DEPTH(D)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .enable_i        (enable_i),
    .clear_i         (clear_i),
    .cycle_cnt_i     (cycle_cnt_i),
    .retire_cnt_i    (retire_cnt_i),
    .alu_op_cnt_i    (alu_op_cnt_i),
    .load_op_cnt_i   (load_op_cnt_i),
    .store_op_cnt_i  (store_op_cnt_i),
    .branch_op_cnt_i (branch_op_cnt_i),
    .sample_ready_i  (sample_ready_i),
    .sample_valid_o  (sample_valid_o),
    .sample_index_o  (sample_index_o),
    .sample_cycles_o (sample_cycles_o),
    .sample_retire_o (sample_retire_o),
    .sample_alu_o    (sample_alu_o),
    .sample_load_o   (sample_load_o),
    .sample_store_o  (sample_store_o),
    .sample_branch_o (sample_branch_o),
    .overflow_o      (overflow_o),
    .drop_cnt_o      (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference behaviour for one rising edge, using the inputs that the edge sees.
  task automatic model_step();
    rec_t r;
    bit   cap;
    bit   pop;
    bit   full;
    r = '0;
    if (reset_i) begin
      m_wc = 0; m_idx = '0; m_ovf = 1'b0; m_drop = '0;
      m_s_cyc = '0; m_s_ret = '0; m_s_alu = '0;
      m_s_ld = '0; m_s_st = '0; m_s_br = '0;
      exp_q.delete();
    end else begin
      full = (exp_q.size() == D);
      pop  = (exp_q.size() != 0) && sample_ready_i;
      cap  = 1'b0;
      if (clear_i) begin
        m_wc = 0;
      end else if (enable_i) begin
        if (m_wc == W - 1) begin
          m_wc = 0;
          cap = 1'b1;
        end else begin
          m_wc++;
        end
      end
      if (cap) begin
        r = {m_idx, cycle_cnt_i - m_s_cyc, retire_cnt_i - m_s_ret,
             alu_op_cnt_i - m_s_alu, load_op_cnt_i - m_s_ld,
             store_op_cnt_i - m_s_st, branch_op_cnt_i - m_s_br};
        m_idx = m_idx + 32'd1;
      end
      if (cap || clear_i) begin
        m_s_cyc = cycle_cnt_i; m_s_ret = retire_cnt_i; m_s_alu = alu_op_cnt_i;
        m_s_ld = load_op_cnt_i; m_s_st = store_op_cnt_i; m_s_br = branch_op_cnt_i;
      end
      if (pop) void'(exp_q.pop_front());
      if (cap) begin
        if (!full || pop) begin
          exp_q.push_back(r);
        end else begin
          m_ovf = 1'b1;
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
      end
    end
  endtask

  // Advances one clock. The scoreboard compare runs on the falling edge,
  // the model step runs at the rising edge, and control returns 1 time
  // unit later.
  task automatic tick();
    rec_t got;
    @(negedge clk_i);
    checks++;
    if (sample_valid_o !== (exp_q.size() != 0)) begin
      failures++;
      $display("[TB] FAIL sb_valid got=%0b exp=%0b", sample_valid_o, exp_q.size() != 0);
    end
    checks++;
    if (overflow_o !== m_ovf) begin
      failures++;
      $display("[TB] FAIL sb_overflow got=%0b exp=%0b", overflow_o, m_ovf);
    end
    checks++;
    if (drop_cnt_o !== m_drop) begin
      failures++;
      $display("[TB] FAIL sb_drop got=%0h exp=%0h", drop_cnt_o, m_drop);
    end
    if (sample_valid_o === 1'b1 && sample_ready_i && exp_q.size() != 0) begin
      got = {sample_index_o, sample_cycles_o, sample_retire_o, sample_alu_o,
             sample_load_o, sample_store_o, sample_branch_o};
      checks++;
      if (got !== exp_q[0]) begin
        failures++;
        $display("[TB] FAIL sb_record got=%h exp=%h", got, exp_q[0]);
      end
    end
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic zero_inputs();
    cycle_cnt_i = '0; retire_cnt_i = '0; alu_op_cnt_i = '0;
    load_op_cnt_i = '0; store_op_cnt_i = '0; branch_op_cnt_i = '0;
    enable_i = 1'b1; clear_i = 1'b0;
  endtask

  task automatic do_reset();
    zero_inputs();
    reset_i = 1'b1;
    repeat (2) tick();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    reset_i = 1'b1; sample_ready_i = 1'b1; enable_i = 1'b1; clear_i = 1'b0;
    cycle_cnt_i = 32'd100; retire_cnt_i = 32'd50; alu_op_cnt_i = 32'd7;
    load_op_cnt_i = 32'd3; store_op_cnt_i = 32'd2; branch_op_cnt_i = 32'd1;
    repeat (3) tick();
    checks++;
    if (sample_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%0b exp=0", sample_valid_o); end
    checks++;
    if (overflow_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got=%0b exp=0", overflow_o); end
    checks++;
    if (drop_cnt_o !== 16'd0) begin failures++; $display("[TB] FAIL reset_drop got=%0h exp=0", drop_cnt_o); end
    checks++;
    if (sample_index_o !== 32'd0 || sample_cycles_o !== 32'd0) begin
      failures++; $display("[TB] FAIL reset_outputs got=%0h/%0h exp=0/0", sample_index_o, sample_cycles_o);
    end
    reset_i = 1'b0;
    repeat (3) tick();
    checks++;
    if (sample_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL first_window_early got=%0b exp=0", sample_valid_o); end
    tick();
    checks++;
    if (sample_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL first_window_valid got=%0b exp=1", sample_valid_o); end
    checks++;
    if (sample_index_o !== 32'd0 || sample_cycles_o !== 32'd100 || sample_retire_o !== 32'd50 || sample_branch_o !== 32'd1) begin
      failures++;
      $display("[TB] FAIL first_window_baseline got=%0d/%0d/%0d/%0d exp=0/100/50/1",
               sample_index_o, sample_cycles_o, sample_retire_o, sample_branch_o);
    end
    tick();
  endtask

  task automatic test_basic_window();
    $display("[TB] test_basic_window");
    sample_ready_i = 1'b1;
    do_reset();
    for (int n = 1; n <= 8; n++) begin
      cycle_cnt_i = 32'(n); retire_cnt_i = 32'(n); alu_op_cnt_i = 32'(n / 2);
      tick();
      if (n == 4 || n == 8) begin
        checks++;
        if (sample_valid_o !== 1'b1 || sample_index_o !== 32'(n / 4 - 1)) begin
          failures++; $display("[TB] FAIL basic_index got=%0b/%0d exp=1/%0d", sample_valid_o, sample_index_o, n / 4 - 1);
        end
        checks++;
        if (sample_cycles_o !== 32'd4 || sample_retire_o !== 32'd4 || sample_alu_o !== 32'd2) begin
          failures++; $display("[TB] FAIL basic_deltas got=%0d/%0d/%0d exp=4/4/2", sample_cycles_o, sample_retire_o, sample_alu_o);
        end
      end
      if (n == 5) begin
        checks++;
        if (sample_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL basic_popped got=%0b exp=0", sample_valid_o); end
      end
    end
  endtask

  task automatic test_overflow();
    $display("[TB] test_overflow");
    sample_ready_i = 1'b0;
    do_reset();
    for (int n = 1; n <= 16; n++) begin
      cycle_cnt_i = 32'(n); retire_cnt_i = 32'(n);
      sample_ready_i = (n >= 13);
      tick();
      if (n == 12) begin
        checks++;
        if (overflow_o !== 1'b1 || drop_cnt_o !== 16'd1) begin
          failures++; $display("[TB] FAIL ovf_flag got=%0b/%0d exp=1/1", overflow_o, drop_cnt_o);
        end
        checks++;
        if (sample_valid_o !== 1'b1 || sample_index_o !== 32'd0) begin
          failures++; $display("[TB] FAIL ovf_head0 got=%0b/%0d exp=1/0", sample_valid_o, sample_index_o);
        end
      end
      if (n == 13) begin
        checks++;
        if (sample_index_o !== 32'd1) begin failures++; $display("[TB] FAIL ovf_head1 got=%0d exp=1", sample_index_o); end
      end
      if (n == 14) begin
        checks++;
        if (sample_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL ovf_drained got=%0b exp=0", sample_valid_o); end
      end
      if (n == 16) begin
        checks++;
        if (sample_valid_o !== 1'b1 || sample_index_o !== 32'd3 || sample_cycles_o !== 32'd4 || overflow_o !== 1'b1) begin
          failures++;
          $display("[TB] FAIL ovf_gap got=%0b/%0d/%0d/%0b exp=1/3/4/1", sample_valid_o, sample_index_o, sample_cycles_o, overflow_o);
        end
      end
    end
  endtask

  task automatic test_full_pop();
    $display("[TB] test_full_pop");
    sample_ready_i = 1'b0;
    do_reset();
    for (int n = 1; n <= 14; n++) begin
      cycle_cnt_i = 32'(n);
      sample_ready_i = (n >= 12);
      tick();
      if (n == 12) begin
        checks++;
        if (overflow_o !== 1'b0 || drop_cnt_o !== 16'd0) begin
          failures++; $display("[TB] FAIL fullpop_noovf got=%0b/%0d exp=0/0", overflow_o, drop_cnt_o);
        end
        checks++;
        if (sample_valid_o !== 1'b1 || sample_index_o !== 32'd1) begin
          failures++; $display("[TB] FAIL fullpop_head got=%0b/%0d exp=1/1", sample_valid_o, sample_index_o);
        end
      end
      if (n == 13) begin
        checks++;
        if (sample_valid_o !== 1'b1 || sample_index_o !== 32'd2) begin
          failures++; $display("[TB] FAIL fullpop_second got=%0b/%0d exp=1/2", sample_valid_o, sample_index_o);
        end
      end
      if (n == 14) begin
        checks++;
        if (sample_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL fullpop_empty got=%0b exp=0", sample_valid_o); end
      end
    end
  endtask

  task automatic test_wrap();
    $display("[TB] test_wrap");
    sample_ready_i = 1'b1;
    do_reset();
    retire_cnt_i = 32'hFFFF_FFFE;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    retire_cnt_i = 32'h0000_0002;
    repeat (3) tick();
    checks++;
    if (sample_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL wrap_early got=%0b exp=0", sample_valid_o); end
    tick();
    checks++;
    if (sample_valid_o !== 1'b1 || sample_retire_o !== 32'd4 || sample_index_o !== 32'd0) begin
      failures++; $display("[TB] FAIL wrap_delta got=%0b/%0h/%0d exp=1/4/0", sample_valid_o, sample_retire_o, sample_index_o);
    end
    tick();
  endtask

  task automatic test_clear_enable();
    $display("[TB] test_clear_enable");
    sample_ready_i = 1'b1;
    do_reset();
    for (int n = 1; n <= 13; n++) begin
      cycle_cnt_i = 32'(n);
      clear_i = (n == 4);
      enable_i = !(n >= 7 && n <= 11);
      tick();
      if (n == 4 || n == 8 || n == 12) begin
        checks++;
        if (sample_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL clear_no_record_%0d got=%0b exp=0", n, sample_valid_o); end
      end
      if (n == 13) begin
        checks++;
        if (sample_valid_o !== 1'b1 || sample_index_o !== 32'd0 || sample_cycles_o !== 32'd9) begin
          failures++; $display("[TB] FAIL clear_rebase got=%0b/%0d/%0d exp=1/0/9", sample_valid_o, sample_index_o, sample_cycles_o);
        end
      end
    end
    clear_i = 1'b0;
    enable_i = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_overflow();
    test_full_pop();
    test_wrap();
    test_clear_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
